// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path.
// ADDR_W is also imported by the icache itself so both agree on addressing.
package icache_pkg;
    localparam int ADDR_W             = 20;
    localparam int LINE_OFF_W         = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_MAX_RETRY      = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2,
        ERR     = 2'd3
    } refill_state_t;
endpackage

// File: rtl/icache_refill_timer.sv
// Per-byte wait timer and retry counter for the refill engine.
// expire flags the last waiting cycle of an attempt; exhausted means no retries remain.
module refill_timer #(
    parameter int TIMEOUT_CYCLES = icache_pkg::DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = icache_pkg::DEF_MAX_RETRY
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic run,
    output logic expire,
    output logic exhausted
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;

    assign expire    = run && (timer == T_LAST);
    assign exhausted = (retry_cnt == R_MAX);

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            timer     <= '0;
            retry_cnt <= '0;
        end else if (run) begin
            if (timer == T_LAST) begin
                timer <= '0;
                // saturate so the count never wraps on the final expiry
                if (!exhausted)
                    retry_cnt <= retry_cnt + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: rtl/icache_refill.sv
// Refill engine: fetches a 32-bit little-endian word as four byte reads from
// program memory on an icache miss, then strobes it back to the icache.
module icache_refill #(
    parameter int ADDR_W         = icache_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = icache_pkg::DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = icache_pkg::DEF_MAX_RETRY
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cache_miss,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              fetch,
    output logic [31:0]       write_data,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              timeout_err
);
    import icache_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFF_W) - 1);

    refill_state_t         state;
    logic [ADDR_W-1:0]     line_addr;
    logic [LINE_OFF_W-1:0] byte_cnt;
    logic                  clr, run, expire, exhausted;

    // mem_req low while in REQ marks the one-cycle gap before a re-issue
    assign run = (state == REQ) && mem_req && !mem_ack;
    assign clr = (state == IDLE) || ((state == REQ) && mem_req && mem_ack);

    refill_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRY      (MAX_RETRY)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (clr),
        .run       (run),
        .expire    (expire),
        .exhausted (exhausted)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            line_addr   <= '0;
            byte_cnt    <= '0;
            fetch       <= 1'b0;
            write_data  <= '0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            timeout_err <= 1'b0;
        end else begin
            fetch <= 1'b0;
            case (state)
                IDLE: begin
                    if (cache_miss) begin
                        line_addr <= miss_addr & LINE_MASK;
                        mem_addr  <= miss_addr & LINE_MASK;
                        byte_cnt  <= '0;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        write_data[8*byte_cnt +: 8] <= mem_rdata;
                        if (byte_cnt == LINE_OFF_W'(3)) begin
                            mem_req <= 1'b0;
                            fetch   <= 1'b1;
                            state   <= DELIVER;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            mem_addr <= line_addr | ADDR_W'(byte_cnt + 1'b1);
                        end
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        if (exhausted) begin
                            timeout_err <= 1'b1;
                            state       <= ERR;
                        end
                    end
                end
                DELIVER: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    // stalled until reset
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: a behavioural memory responder checks the
// byte request stream and a monitor checks fetch timing and the assembled word.
module tb_icache_refill;
    localparam int AW = 20;
    localparam int T  = 8;
    localparam int MR = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cache_miss = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic          fetch, busy, mem_req, timeout_err;
    logic [31:0]   write_data;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = '0;

    icache_refill #(.ADDR_W(AW), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .CLK(CLK), .RST(RST), .cache_miss(cache_miss), .miss_addr(miss_addr),
        .fetch(fetch), .write_data(write_data), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Program memory image, filled lazily with random bytes
    logic [7:0] mem_img [int];
    function automatic logic [7:0] get_byte(input logic [AW-1:0] a);
        if (!mem_img.exists(int'(a))) mem_img[int'(a)] = 8'($urandom);
        return mem_img[int'(a)];
    endfunction

    // Responder behaviour for the current refill
    int cfg_wait [4];
    int cfg_fail_byte = -1;
    int cfg_fail_n    = 0;
    bit cfg_never     = 0;

    typedef struct { logic [31:0] word; int e0; int fe; } exp_t;
    exp_t          expq  [$];
    logic [AW-1:0] addrq [$];

    // Memory responder: checks each requested address against the expected
    // byte stream, attempt length and retry gap, and acks after the wait count.
    int            r_cnt = 0, r_att = 0;
    bit            p_req = 0, p_ack = 0, gap_exp = 0;
    always @(posedge CLK) begin
        bit ack;
        int bi;
        #1;
        ack = 0;
        if (RST) begin
            r_cnt = 0; r_att = 0; p_req = 0; p_ack = 0; gap_exp = 0;
        end else begin
            if (gap_exp) begin
                check("retry_gap_len", 32'(mem_req), 32'd1);
                gap_exp = 0;
            end
            if (!mem_req && p_req && !p_ack) begin
                check("attempt_len", 32'(r_cnt), 32'(T));
                r_att++;
                r_cnt = 0;
                gap_exp = (r_att <= MR);
            end
            if (mem_req) begin
                if (addrq.size() == 0) begin
                    check("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    check("mem_addr", 32'(mem_addr), 32'(addrq[0]));
                    r_cnt++;
                    bi = int'(addrq[0][1:0]);
                    if (!cfg_never && !(bi == cfg_fail_byte && r_att < cfg_fail_n) &&
                        r_cnt == cfg_wait[bi] + 1) begin
                        ack = 1;
                        mem_rdata = get_byte(addrq[0]);
                        void'(addrq.pop_front());
                        r_att = 0;
                        r_cnt = 0;
                    end
                end
            end
            p_req = mem_req;
        end
        p_ack = ack;
        mem_ack = ack;
        if (!ack) mem_rdata = 8'($urandom);
    end

    // Fetch monitor: busy through the refill window, fetch exactly at the
    // predicted cycle with the predicted word, and never otherwise.
    always @(negedge CLK) begin
        if (!RST) begin
            if (expq.size() > 0 && cyc >= expq[0].e0) begin
                check("busy_in_refill", 32'(busy), 32'd1);
                if (cyc == expq[0].fe) begin
                    check("fetch_pulse", 32'(fetch), 32'd1);
                    check("write_data", write_data, expq[0].word);
                    void'(expq.pop_front());
                end else begin
                    check("fetch_early", 32'(fetch), 32'd0);
                end
            end else begin
                check("fetch_spurious", 32'(fetch), 32'd0);
            end
        end
    end

    // Called at #1 after a clock edge; returns at the same phase.
    task automatic refill(input logic [AW-1:0] a, input bit chg_addr);
        logic [AW-1:0] line;
        exp_t e;
        int   lat;
        bit   seen;
        line = a & ~AW'(3);
        lat  = 0;
        seen = 0;
        e.word = '0;
        for (int b = 0; b < 4; b++) begin
            addrq.push_back(line + AW'(b));
            e.word[8*b +: 8] = get_byte(line + AW'(b));
            lat += ((b == cfg_fail_byte) ? cfg_fail_n * (T + 1) : 0) + cfg_wait[b] + 1;
        end
        e.e0 = cyc + 1;
        e.fe = e.e0 + lat;
        expq.push_back(e);
        miss_addr  = a;
        cache_miss = 1'b1;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge CLK); #1;
            if (chg_addr && i == 2) miss_addr = AW'($urandom);
            if (fetch) seen = 1;
        end
        cache_miss = 1'b0;
        if (!seen) check("fetch_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(input int w, input int fb, input int fn);
        for (int b = 0; b < 4; b++) cfg_wait[b] = w;
        cfg_fail_byte = fb;
        cfg_fail_n    = fn;
        cfg_never     = 0;
    endtask

    initial begin
        logic [AW-1:0] line;
        int e0;
        set_cfg(0, -1, 0);
        // reset then idle
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("idle_out", {28'd0, fetch, mem_req, busy, timeout_err}, 32'd0);
        end
        check("reset_write_data", write_data, 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);

        // zero-wait directed refill
        mem_img[32'h01234] = 8'h13;
        mem_img[32'h01235] = 8'h01;
        mem_img[32'h01236] = 8'h10;
        mem_img[32'h01237] = 8'h00;
        refill(20'h01236, 0);
        check("directed_word", write_data, 32'h00100113);

        // three wait states per byte, miss_addr changed mid-refill
        set_cfg(3, -1, 0);
        refill(20'h5a5a8, 1);

        // byte 2 times out once, acked on the retry
        set_cfg(0, 2, 1);
        refill(20'hbeef1, 0);
        check("no_err_after_retry", 32'(timeout_err), 32'd0);

        // randomized refills
        for (int t = 0; t < 16; t++) begin
            for (int b = 0; b < 4; b++) cfg_wait[b] = $urandom_range(0, 4);
            cfg_fail_byte = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            cfg_fail_n    = $urandom_range(1, MR);
            refill(AW'($urandom), (t % 4) == 0);
        end

        // reset after two bytes
        set_cfg(0, -1, 0);
        line = 20'h33330;
        for (int b = 0; b < 4; b++) addrq.push_back(line + AW'(b));
        miss_addr  = line;
        cache_miss = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        cache_miss = 1'b0;
        addrq.delete();
        @(posedge CLK); #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_fetch", 32'(fetch), 32'd0);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // retry exhaustion on byte 0
        set_cfg(0, -1, 0);
        cfg_never = 1;
        line = 20'h77770;
        addrq.push_back(line);
        e0 = cyc + 1;
        miss_addr  = line + AW'(1);
        cache_miss = 1'b1;
        while (cyc < e0 + (MR + 1) * T + MR - 1) begin
            @(posedge CLK); #1;
        end
        check("err_not_early", 32'(timeout_err), 32'd0);
        @(posedge CLK); #1;
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        repeat (10) @(posedge CLK);
        #1;
        check("err_sticky", {29'd0, timeout_err, busy, mem_req}, 32'b110);
        cache_miss = 1'b0;
        addrq.delete();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("err_cleared", {28'd0, fetch, mem_req, busy, timeout_err}, 32'd0);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("expq_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
